note_player: RTL and testbench

- Playback engine; the reader for the note sequences that `recorder` writes.
- Recorder stores one entry per key-state change: switch pattern plus hold duration, in a synchronous RAM.
- note_player walks that RAM from address 0 and drives the recorded 4-bit key pattern with recorded timing.
- Its `keys_out` feeds `gui` and `sound` in place of `SW[3:0]` while `mode` selects playback.

---
 rtl/note_player.sv | 142 ++++++++++++++
 tb/tb_note_player.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_player.sv
// Playback engine for recorder note RAM: fetches {keys, duration} entries from
// address 0 and replays the key pattern for duration ticks of TICK_DIV clocks each.
module note_player #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DUR_WIDTH  = 16,
    parameter int unsigned TICK_DIV   = 500000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      loop,
    input  logic [ADDR_WIDTH:0]       length,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic                      mem_rd,
    input  logic [DUR_WIDTH+3:0]      mem_data,
    output logic [3:0]                keys_out,
    output logic                      playing,
    output logic                      done
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 1;
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(1) << ADDR_WIDTH;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                 state;
    logic [LEN_W-1:0]       len_q;
    logic [ADDR_WIDTH-1:0]  index;
    logic [PRE_W-1:0]       presc;
    logic [DUR_WIDTH-1:0]   tick_cnt;
    logic [DUR_WIDTH-1:0]   dur_q;

    logic                   wrap;
    logic                   is_last;
    logic [DUR_WIDTH-1:0]   tick_next;
    logic [3:0]             rd_keys;
    logic [DUR_WIDTH-1:0]   rd_dur;

    assign wrap      = (presc == PRE_LAST);
    assign is_last   = ({1'b0, index} == (len_q - LEN_W'(1)));
    assign tick_next = tick_cnt + DUR_WIDTH'(1);
    assign rd_keys   = mem_data[DUR_WIDTH+3:DUR_WIDTH];
    assign rd_dur    = mem_data[DUR_WIDTH-1:0];

    // Sequencer: state, counters and all registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            len_q    <= '0;
            index    <= '0;
            presc    <= '0;
            tick_cnt <= '0;
            dur_q    <= '0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            keys_out <= '0;
            playing  <= 1'b0;
            done     <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            done   <= 1'b0;
            if (stop && (state != S_IDLE)) begin
                state    <= S_IDLE;
                keys_out <= '0;
                playing  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !stop) begin
                            keys_out <= '0;
                            playing  <= 1'b1;
                            if (length != '0) begin
                                len_q    <= (length > MAX_LEN) ? MAX_LEN : length;
                                index    <= '0;
                                mem_addr <= '0;
                                mem_rd   <= 1'b1;
                                state    <= S_FETCH;
                            end else begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                        end
                    end
                    S_FETCH: begin
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        // A zero duration still plays for one tick
                        keys_out <= rd_keys;
                        dur_q    <= (rd_dur == '0) ? DUR_WIDTH'(1) : rd_dur;
                        presc    <= '0;
                        tick_cnt <= '0;
                        state    <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (wrap) begin
                            presc    <= '0;
                            tick_cnt <= tick_next;
                            if (tick_next == dur_q) begin
                                if (!is_last) begin
                                    index    <= index + ADDR_WIDTH'(1);
                                    mem_addr <= index + ADDR_WIDTH'(1);
                                    mem_rd   <= 1'b1;
                                    state    <= S_FETCH;
                                end else if (loop) begin
                                    index    <= '0;
                                    mem_addr <= '0;
                                    mem_rd   <= 1'b1;
                                    state    <= S_FETCH;
                                end else begin
                                    keys_out <= '0;
                                    done     <= 1'b1;
                                    state    <= S_DONE;
                                end
                            end
                        end else begin
                            presc <= presc + PRE_W'(1);
                        end
                    end
                    S_DONE: begin
                        playing <= 1'b0;
                        state   <= S_IDLE;
                    end
                    default: begin
                        playing <= 1'b0;
                        state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Randomized scoreboard bench for note_player: a cycle-timed event model predicts
// every read strobe, keys_out change and done pulse; a monitor matches them.
module tb_note_player;

    localparam int AW   = 5;
    localparam int DW   = 16;
    localparam int T    = 4;
    localparam int NENT = 32;
    localparam int BIG  = 1 << 30;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic          loop  = 1'b0;
    logic [AW:0]   length = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW+3:0] mem_data = '0;
    logic [3:0]    keys_out;
    logic          playing;
    logic          done;

    note_player #(.ADDR_WIDTH(AW), .DUR_WIDTH(DW), .TICK_DIV(T)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .length(length), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .keys_out(keys_out), .playing(playing), .done(done)
    );

    always #5 clock = ~clock;

    logic [DW+3:0] ram [NENT];
    always @(posedge clock) if (mem_rd) mem_data <= ram[mem_addr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;
    ev_t q[$];

    int checks = 0;
    int errors = 0;
    int play_cnt = 0;
    logic [3:0] prev_keys = '0;

    function automatic string kname(input int k);
        if (k == 0) return "mem_rd";
        if (k == 1) return "keys_out";
        return "done";
    endfunction

    function automatic void push(input int k, input int v, input int c);
        ev_t e;
        e.kind = k; e.val = v; e.cyc = c;
        q.push_back(e);
    endfunction

    function automatic int dur_of(input int i);
        int d;
        d = int'(ram[i][DW-1:0]);
        return (d == 0) ? 1 : d;
    endfunction

    // Cycle at which the k-th fetch (0-based) is presented, entries repeating every n
    function automatic int fetch_cycle(input int p, input int k, input int n);
        int f;
        f = p;
        for (int i = 0; i < k; i++) f += 2 + dur_of(i % n) * T;
        return f;
    endfunction

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    task automatic chk_event(input int k, input int v);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected %s event: got val=%0d at cycle %0d, required none", kname(k), v, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.val != v || e.cyc != cyc) begin
                errors++;
                $display("FAIL %s event: got %s val=%0d cycle=%0d, required %s val=%0d cycle=%0d",
                         kname(k), kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    // Monitor: every observable event is matched against the scoreboard queue
    always @(negedge clock) begin
        if (reset) begin
            if (playing) play_cnt++;
            if (mem_rd) chk_event(0, int'(mem_addr));
            if (keys_out != prev_keys) chk_event(1, int'(keys_out));
            if (done) chk_event(2, 0);
        end
        prev_keys = keys_out;
    end

    // Reference model: walks entries with plain cycle arithmetic, stopping at 'abort'
    task automatic model_play(input int p, input int len, input bit lp, input int loop_clr,
                              input int abort, input bit by_stop, output int play_exp);
        int n, f, idx, prev, kv, end_c;
        n = (len > NENT) ? NENT : len;
        prev = 0;
        if (n == 0) begin
            push(2, 0, p);
            play_exp = 1;
            return;
        end
        f = p;
        idx = 0;
        forever begin
            if (f >= abort) break;
            push(0, idx, f);
            kv = int'(ram[idx][DW+3:DW]);
            if (f + 2 >= abort) break;
            if (kv != prev) begin
                push(1, kv, f + 2);
                prev = kv;
            end
            end_c = f + 2 + dur_of(idx) * T;
            if (end_c >= abort) break;
            if (idx < n - 1) begin
                idx++;
                f = end_c;
            end else if (lp && end_c <= loop_clr) begin
                idx = 0;
                f = end_c;
            end else begin
                if (prev != 0) push(1, 0, end_c);
                push(2, 0, end_c);
                play_exp = end_c - p + 1;
                return;
            end
        end
        if (by_stop && prev != 0) push(1, 0, abort);
        play_exp = abort - p;
    endtask

    task automatic begin_start(output int p);
        @(negedge clock);
        #1;
        p = cyc + 1;
        play_cnt = 0;
    endtask

    task automatic fire(input int len);
        start = 1'b1;
        length = (AW+1)'(len);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run(input int s_cyc, input int l_cyc, input int x_cyc,
                       input int play_exp, input string tag);
        int n;
        n = 0;
        while ((q.size() != 0 || cyc <= s_cyc + 2 || n < 4) && n < 3000) begin
            @(negedge clock);
            stop  = (cyc == s_cyc - 1);
            start = (cyc == x_cyc);
            if (cyc == x_cyc) length = (AW+1)'(7);
            if (cyc == l_cyc) loop = 1'b0;
            n++;
        end
        stop = 1'b0;
        start = 1'b0;
        #1;
        check({tag, "_pending_events"}, q.size(), 0);
        check({tag, "_playing_cycles"}, play_cnt, play_exp);
        check({tag, "_playing_end"}, int'(playing), 0);
        check({tag, "_keys_end"}, int'(keys_out), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_keys"}, int'(keys_out), 0);
        check({tag, "_addr"}, int'(mem_addr), 0);
        check({tag, "_rd"}, int'(mem_rd), 0);
        check({tag, "_playing"}, int'(playing), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NENT; i++)
            ram[i] = {4'($urandom), DW'($urandom_range(0, 3))};
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        int p, pe, s, l, k, f, len, mode, w, n;
        for (int i = 0; i < NENT; i++) ram[i] = '0;

        repeat (3) @(negedge clock);
        check_zero("reset");
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);

        // Zero length goes straight to DONE
        begin_start(p);
        model_play(p, 0, 1'b0, BIG, BIG, 1'b0, pe);
        fire(0);
        run(-10, -1, -1, pe, "len0");

        // Directed three-entry sequence with an ignored restart and length change
        ram[0] = {4'h1, DW'(2)};
        ram[1] = {4'h6, DW'(1)};
        ram[2] = {4'h9, DW'(3)};
        loop = 1'b0;
        begin_start(p);
        model_play(p, 3, 1'b0, BIG, BIG, 1'b0, pe);
        fire(3);
        run(-10, -1, p + 5, pe, "seq3");

        // Zero duration entry plays like duration 1
        ram[0] = {4'hA, DW'(0)};
        ram[1] = {4'h5, DW'(1)};
        begin_start(p);
        model_play(p, 2, 1'b0, BIG, BIG, 1'b0, pe);
        fire(2);
        run(-10, -1, -1, pe, "dur0");

        // Looping pair, stopped mid-hold
        ram[0] = {4'h3, DW'(1)};
        ram[1] = {4'hC, DW'(2)};
        loop = 1'b1;
        begin_start(p);
        s = fetch_cycle(p, 5, 2) + 4;
        model_play(p, 2, 1'b1, BIG, s, 1'b1, pe);
        fire(2);
        run(s, -1, -1, pe, "loop_stop");
        loop = 1'b0;

        // start and stop together in IDLE
        @(negedge clock);
        start = 1'b1; stop = 1'b1; length = (AW+1)'(3);
        @(negedge clock);
        start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("start_stop_idle_playing", int'(playing), 0);
        check("start_stop_idle_rd", int'(mem_rd), 0);

        // Asynchronous reset during WAIT, then a clean replay
        fill_random();
        begin_start(p);
        w = fetch_cycle(p, 1, 3) + 1;
        model_play(p, 3, 1'b0, BIG, w + 1, 1'b0, pe);
        fire(3);
        n = 0;
        while (cyc != w && n < 200) begin
            @(negedge clock);
            n++;
        end
        #2 reset = 1'b0;
        #1;
        check_zero("async_reset");
        check("async_reset_pending", q.size(), 0);
        check("async_reset_playing_cycles", play_cnt, pe);
        @(negedge clock);
        #1 reset = 1'b1;
        begin_start(p);
        model_play(p, 3, 1'b0, BIG, BIG, 1'b0, pe);
        fire(3);
        run(-10, -1, -1, pe, "after_reset");

        // Randomized sequences: plain, looping with stop, looping with late loop clear
        for (int it = 0; it < 20; it++) begin
            fill_random();
            len = $urandom_range(0, 40);
            mode = (len == 0) ? 0 : $urandom_range(0, 2);
            n = (len > NENT) ? NENT : len;
            begin_start(p);
            s = -10;
            l = -1;
            if (mode == 1) begin
                loop = 1'b1;
                k = $urandom_range(0, 2 * n);
                f = fetch_cycle(p, k, n);
                s = f + 3 + $urandom_range(0, dur_of(k % n) * T - 1);
                model_play(p, len, 1'b1, BIG, s, 1'b1, pe);
            end else if (mode == 2) begin
                loop = 1'b1;
                l = p + 5 + $urandom_range(0, 60);
                model_play(p, len, 1'b1, l, BIG, 1'b0, pe);
            end else begin
                loop = 1'b0;
                model_play(p, len, 1'b0, BIG, BIG, 1'b0, pe);
            end
            fire(len);
            run(s, l, -1, pe, "rand");
            loop = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
